// File: rtl/pc_run_ctrl.sv
// =============================================================================
// pc_run_ctrl : run/step/breakpoint controller and next-PC generator for the PC register
// Revision    : 1.0
// =============================================================================
`default_nettype none

module pc_run_ctrl #(
    parameter int DATA_WIDTH      = 32,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic                  br_taken,
    input  logic [DATA_WIDTH-1:0] br_target,
    input  logic                  jal,
    input  logic [DATA_WIDTH-1:0] jal_target,
    input  logic                  jalr,
    input  logic [DATA_WIDTH-1:0] jalr_target,
    input  logic                  run_btn,
    input  logic                  step_btn,
    input  logic                  bp_en,
    input  logic [DATA_WIDTH-1:0] bp_addr,
    output logic [DATA_WIDTH-1:0] pc_next,
    output logic                  pc_en,
    output logic [1:0]            state,
    output logic                  halted,
    output logic [DATA_WIDTH-1:0] instr_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_STEP  = 2'b10,
        S_BREAK = 2'b11
    } state_t;

    localparam int               CNT_W    = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t                  state_q;
    logic                    skip_q;
    logic [DATA_WIDTH-1:0]   instr_count_q;
    logic [1:0]              btn_raw;
    logic [1:0]              btn_p;
    logic                    run_p;
    logic                    step_p;
    logic                    bp_hit;

    assign btn_raw = {step_btn, run_btn};
    assign run_p   = btn_p[0];
    assign step_p  = btn_p[1];

    // Synchronize, debounce, then pulse once on the accepted level's rising edge
    generate
        for (genvar b = 0; b < 2; b++) begin : g_btn
            logic             sync1_q;
            logic             sync2_q;
            logic             level_q;
            logic             level_prev_q;
            logic [CNT_W-1:0] cnt_q;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    sync1_q      <= 1'b0;
                    sync2_q      <= 1'b0;
                    level_q      <= 1'b0;
                    level_prev_q <= 1'b0;
                    cnt_q        <= '0;
                end else begin
                    sync1_q      <= btn_raw[b];
                    sync2_q      <= sync1_q;
                    level_prev_q <= level_q;
                    if (sync2_q == level_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        level_q <= sync2_q;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
            end

            assign btn_p[b] = level_q & ~level_prev_q;
        end
    endgenerate

    always_comb begin
        pc_next = pc + DATA_WIDTH'(4);
        if (jalr) begin
            pc_next = {jalr_target[DATA_WIDTH-1:1], 1'b0};
        end else if (jal) begin
            pc_next = jal_target;
        end else if (br_taken) begin
            pc_next = br_target;
        end
    end

    assign bp_hit = bp_en & (pc == bp_addr) & ~skip_q;
    assign pc_en  = ((state_q == S_RUN) & ~bp_hit) | (state_q == S_STEP);

    // skip lets a resumed breakpoint instruction execute once before re-arming
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            skip_q        <= 1'b0;
            instr_count_q <= '0;
        end else begin
            if (pc_en) begin
                instr_count_q <= instr_count_q + DATA_WIDTH'(1);
                skip_q        <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (run_p) begin
                        state_q <= S_RUN;
                    end else if (step_p) begin
                        state_q <= S_STEP;
                    end
                end
                S_RUN: begin
                    if (bp_hit) begin
                        state_q <= S_BREAK;
                    end else if (run_p) begin
                        state_q <= S_IDLE;
                    end
                end
                S_STEP: begin
                    state_q <= S_IDLE;
                end
                S_BREAK: begin
                    if (run_p) begin
                        state_q <= S_RUN;
                        skip_q  <= 1'b1;
                    end else if (step_p) begin
                        state_q <= S_STEP;
                        skip_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign state       = state_q;
    assign halted      = (state_q == S_BREAK);
    assign instr_count = instr_count_q;

endmodule

`default_nettype wire

// File: doc/pc_run_ctrl.md
Name: pc_run_ctrl

Overview:
- Run/step/breakpoint controller and next-PC generator directly upstream of the PC register.
- Produces the PC register's data input (pc_next) and its write enable (pc_en) from branch/jump resolution, debounced board buttons and a single address breakpoint.
- Reads back the current PC (pc) so the processor can be free-run, single-stepped or halted on a breakpoint for debug.

Parameters:
DATA_WIDTH, 32, width of PC, targets and breakpoint address
DEBOUNCE_CYCLES, 4, cycles a synchronized button level must stay stable before it is accepted (range 1..65535)

Ports:
clk  input  1  system clock, all state on rising edge
rstn  input  1  asynchronous active-low reset
pc  input  DATA_WIDTH  current PC (PC register output)
br_taken  input  1  conditional branch resolved taken
br_target  input  DATA_WIDTH  branch target
jal  input  1  direct jump
jal_target  input  DATA_WIDTH  direct jump target
jalr  input  1  register-indirect jump
jalr_target  input  DATA_WIDTH  indirect jump target (raw sum)
run_btn  input  1  asynchronous run/pause button, active-high
step_btn  input  1  asynchronous single-step button, active-high
bp_en  input  1  breakpoint enable
bp_addr  input  DATA_WIDTH  breakpoint address
pc_next  output  DATA_WIDTH  next PC value for the PC register
pc_en  output  1  PC register write enable
state  output  2  FSM state: 00 IDLE, 01 RUN, 10 STEP, 11 BREAK
halted  output  1  high while state is BREAK
instr_count  output  DATA_WIDTH  number of cycles with pc_en high since reset

Behaviour:
- Reset (rstn low, asynchronous): state=IDLE, instr_count=0, skip flag=0, synchronizer/debounce/edge registers=0; hence pc_en=0, halted=0.
- pc_next (combinational), priority jalr > jal > br_taken > sequential: jalr_target with bit0 forced to 0; jal_target; br_target; pc+4, modulo 2^DATA_WIDTH (0xFFFFFFFC+4 = 0). Independent of state.
- Buttons:
  - Each button passes through 2-flop synchronizer, then debounce counter.
  - The accepted level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
  - A one-cycle pulse (run_p/step_p) is generated on the accepted level's rising edge only.
  - Holding a button produces exactly one pulse. Earliest pulse is 2+DEBOUNCE_CYCLES cycles after the input rises.
- bp_hit = bp_en & (pc == bp_addr) & ~skip.
- pc_en (combinational) = (state==RUN & ~bp_hit) | (state==STEP).
- FSM transitions, evaluated each rising edge:
  - IDLE: run_p -> RUN; else step_p -> STEP. If both pulse together, run wins.
  - RUN: bp_hit -> BREAK (takes priority over run_p); else run_p -> IDLE; step_p ignored.
  - STEP: always -> IDLE after exactly one cycle; buttons ignored; breakpoint ignored.
  - BREAK: run_p -> RUN and set skip; else step_p -> STEP and set skip.
- skip flag:
  - Cleared on any cycle with pc_en=1.
  - Guarantees resuming from a breakpoint executes the breakpoint instruction once instead of re-halting.
  - Set-and-clear in the same edge is impossible, since BREAK has pc_en=0.
- instr_count: +1 on each edge where pc_en=1; wraps at 2^DATA_WIDTH to 0.
- halted = (state==BREAK), registered via state.
- Reset mid-RUN: pc_en drops immediately (asynchronous). The PC register keeps its own value; this block does not reset the PC.
- Breakpoint while IDLE or STEP: no effect. bp_en deasserted while in BREAK: the block stays in BREAK until a button pulse.

Test Plan:
- Reset, then run_btn high 10 cycles, DEBOUNCE_CYCLES=4, PC model starting 0x2ffc -> exactly one run_p; state RUN; pc sequence 0x3000, 0x3004, ...; instr_count counts each advance.
- run_btn glitch high 2 cycles, low 3, high 2 -> no pulse; state stays IDLE; pc_en=0 throughout.
- bp_en=1, bp_addr=0x3008, RUN from 0x3000 -> pc_en low when pc=0x3008; state BREAK, halted=1, instr_count=2. Then step_btn pulse -> one cycle pc_en=1, pc=0x300C, state IDLE.
- From BREAK at 0x3008, run pulse -> passes 0x3008 without re-halting. With a backward branch looping to 0x3008 -> halts again on the next arrival.
- Next-PC priority: jalr=1, jalr_target=0x3011, jal=1, br_taken=1 -> pc_next=0x3010. jal only -> jal_target. None with pc=0xFFFFFFFC -> pc_next=0.
- rstn low during RUN -> pc_en=0 and state=IDLE within the same cycle; instr_count=0; resumes only after a new run_p.
